// File: rtl/fifo_rr_arbiter.sv
// Round-robin write-side arbiter in front of a shared bus FIFO.
// Grants one requester per cycle, supports bounded bursts, and tracks FIFO occupancy.
module fifo_rr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CAP       = 15,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*WIDTH-1:0]    req_data_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [WIDTH-1:0]          fifo_data_o,
    output logic                      fifo_enq_o,
    input  logic                      fifo_deq_i,
    output logic [$clog2(CAP+1)-1:0]  count_o,
    output logic                      full_o,
    output logic                      busy_o
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(CAP + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q;

    logic            space;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic            deq_eff;

    // Next-state and grant decision
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        beats_d   = beats_q;
        grant_vld = 1'b0;
        grant_idx = owner_q;
        pick_vld  = 1'b0;
        pick_idx  = '0;
        cand      = '0;
        space     = (count_q < CW'(CAP));

        // Descending scan so the requester closest to rr_ptr wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((32'(rr_ptr_q) + 32'(k)) % 32'(N_REQ));
            if (req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (space && pick_vld) begin
                    grant_vld = 1'b1;
                    grant_idx = pick_idx;
                    owner_d   = pick_idx;
                    beats_d   = BW'(1);
                    if (MAX_BURST > 1) begin
                        state_d = BURST;
                    end else begin
                        rr_ptr_d = IW'((32'(pick_idx) + 32'd1) % 32'(N_REQ));
                    end
                end
            end
            BURST: begin
                if (req_i[owner_q]) begin
                    if (space) begin
                        grant_vld = 1'b1;
                        beats_d   = beats_q + BW'(1);
                        if (beats_q + BW'(1) == BW'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = IW'((32'(owner_q) + 32'd1) % 32'(N_REQ));
                        end
                    end
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = IW'((32'(owner_q) + 32'd1) % 32'(N_REQ));
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst_i) begin
            grant_vld = 1'b0;
        end
    end

    // Occupancy tracking; a deq on an empty FIFO is ignored
    always_comb begin
        deq_eff = fifo_deq_i && (count_q != '0);
        case ({grant_vld, deq_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beats_q  <= beats_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(CAP));
        end
    end

    assign gnt_o       = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
    assign fifo_enq_o  = grant_vld;
    assign fifo_data_o = grant_vld ? req_data_i[32'(grant_idx)*WIDTH +: WIDTH] : '0;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign busy_o      = (state_q == BURST);

endmodule
